exp_coeff_bank_ctrl: RTL and testbench
======================================

EXP_COEFF_BANK_CTRL -- requirements
Module: exp_coeff_bank_ctrl

Interface
REQ-001 SHALL have parameter Q, default 26, fraction bits of coefficients.
REQ-002 SHALL have parameter W, default 32, signed coefficient width.
REQ-003 SHALL have parameter NUM_SEGMENTS, default 8, entries per bank (power of two).
REQ-004 SHALL have parameter NUM_PORTS, default 32, parallel lookup ports.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_valid  in  1  config beat valid.
REQ-008 cfg_ready  out  1  config beat accepted when high with cfg_valid.
REQ-009 cfg_seg  in  $clog2(NUM_SEGMENTS)  segment being written.
REQ-010 cfg_k, cfg_b  in  W each  signed slope / intercept, Q-format.
REQ-011 cfg_last  in  1  final beat of a table load.
REQ-012 lut_busy  in  1  downstream exp datapath has lookups in flight; blocks bank swap.
REQ-013 lk_valid  in  1  lookup request valid.
REQ-014 lk_seg  in  [NUM_PORTS] x $clog2(NUM_SEGMENTS)  per-port segment index.
REQ-015 lk_valid_o  out  1  lookup result valid.
REQ-016 k_coeff, b_intercept  out  [NUM_PORTS] x W  per-port coefficients.
REQ-017 active_bank  out  1  bank currently serving lookups.
REQ-018 swap_done  out  1  one-cycle pulse when a new bank becomes active.
REQ-019 cfg_err  out  1  one-cycle pulse on an incomplete load.

Function
REQ-020 SHALL hold two banks (0, 1), each NUM_SEGMENTS {k, b} pairs; the active bank serves lookups, the other is the shadow bank.
REQ-021 Lookup: lk_valid at cycle N SHALL produce k_coeff/b_intercept from the active bank at cycle N and lk_valid_o=1 at N+1 (one registered stage); outputs hold their value when lk_valid=0.
REQ-022 Every config beat SHALL write the shadow bank only and set bit cfg_seg of an entry mask; rewriting a segment overwrites it.
REQ-023 FSM states: IDLE, LOAD, WAIT_SWAP, SWAP.
REQ-024 IDLE -> LOAD on the first accepted beat without cfg_last; IDLE/LOAD -> WAIT_SWAP on an accepted beat with cfg_last when the mask, including that beat, is all ones.
REQ-025 An accepted cfg_last beat with an incomplete mask SHALL pulse cfg_err, clear the mask, discard the load (no swap), and return to IDLE.
REQ-026 cfg_ready SHALL be 1 in IDLE/LOAD and 0 in WAIT_SWAP/SWAP.
REQ-027 WAIT_SWAP -> SWAP in the first cycle with lut_busy=0; waiting is unbounded.
REQ-028 In SWAP: toggle active_bank, pulse swap_done, clear the mask, go to IDLE; a lookup issued in the SWAP cycle SHALL use the old bank, the next cycle the new bank.
REQ-029 The bank being read SHALL never be written; the new shadow bank (old active) keeps stale data until overwritten.

Reset
REQ-030 On rst_n=0 both banks SHALL load the default table, state=IDLE, active_bank=0, mask=0, lk_valid_o=0, k_coeff=b_intercept=0, swap_done=cfg_err=0, cfg_ready=0 during reset, 1 the first cycle after.
REQ-031 Default k (hex, seg 0..7): 02E57078 03288B9B 0371B996 03C18722 04188DB7 047774AE 04DEF287 054FCE46.
REQ-032 Default b (hex, seg 0..7): 04000000 03F79C9B 03E5511D 03C76408 039BE0BD 03609063 0312F200 02B031B9.
REQ-033 Reset during LOAD or WAIT_SWAP SHALL abandon the load; no partial table becomes active.

Structure
REQ-034 Package exp_lut_pkg SHALL hold Q, W, NUM_SEGMENTS, default k/b tables and the FSM state enum.
REQ-035 Sub-module exp_coeff_bank SHALL hold one bank: one write port, NUM_PORTS combinational read ports; instantiated twice.

Verification
REQ-036 Post-reset: all lk_seg=0, lk_valid=1 -> next cycle every port k=02E57078, b=04000000, active_bank=0.
REQ-037 Load 8 beats k=b=seg+1 (raw), last on seg 7, lut_busy=0 -> swap_done pulses, active_bank=1, lookup seg 5 returns k=b=00000006.
REQ-038 Same load with lut_busy=1 for 20 cycles -> cfg_ready=0, lookups still return defaults, swap_done exactly one cycle after lut_busy falls.
REQ-039 Load segs 0..6 only, cfg_last on seg 6 -> cfg_err pulse, no swap_done, active_bank unchanged, lookups return defaults.
REQ-040 lk_valid in SWAP cycle with lk_seg[0]=3 -> returns old 03C18722; next cycle returns new value.
REQ-041 rst_n low mid-load after 4 beats -> after release active_bank=0, defaults returned, mask empty (fresh 8-beat load required to swap).

Source files
------------

// File: rtl/exp_lut_pkg.sv
// rtl/exp_lut_pkg.sv - shared constants, default coefficient table and FSM states
//
// Purpose: coefficient format constants, the power-on exp() segment table
// and the bank controller state encoding, shared by the bank and controller.
// Ports: none (package).
package exp_lut_pkg;

  localparam int Q            = 26;
  localparam int W            = 32;
  localparam int NUM_SEGMENTS = 8;

  // Power-on slope/intercept table, Q6.26, one entry per segment.
  localparam logic [31:0] DEFAULT_K [8] = '{
    32'h02E57078, 32'h03288B9B, 32'h0371B996, 32'h03C18722,
    32'h04188DB7, 32'h047774AE, 32'h04DEF287, 32'h054FCE46
  };
  localparam logic [31:0] DEFAULT_B [8] = '{
    32'h04000000, 32'h03F79C9B, 32'h03E5511D, 32'h03C76408,
    32'h039BE0BD, 32'h03609063, 32'h0312F200, 32'h02B031B9
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_SWAP,
    ST_SWAP
  } state_t;

  // Segments beyond the built-in table power up as zero.
  function automatic logic [31:0] default_k(input int seg);
    if (seg >= 0 && seg < 8) return DEFAULT_K[seg[2:0]];
    return '0;
  endfunction

  function automatic logic [31:0] default_b(input int seg);
    if (seg >= 0 && seg < 8) return DEFAULT_B[seg[2:0]];
    return '0;
  endfunction

endpackage

// File: rtl/exp_coeff_bank.sv
// rtl/exp_coeff_bank.sv - one coefficient bank, single write port, many read ports
//
// Purpose: NUM_SEGMENTS {k, b} registers, loaded with the default table on
// reset, one synchronous write port and NUM_PORTS combinational read ports.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_we              write enable
//   i_wseg            segment written
//   i_wk, i_wb        slope / intercept written
//   i_rseg            packed per-port read segment indices
//   o_rk, o_rb        packed per-port slope / intercept read data
module exp_coeff_bank #(
  parameter int W            = exp_lut_pkg::W,
  parameter int NUM_SEGMENTS = exp_lut_pkg::NUM_SEGMENTS,
  parameter int NUM_PORTS    = 32,
  localparam int SW          = $clog2(NUM_SEGMENTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [SW-1:0]           i_wseg,
  input  logic [W-1:0]            i_wk,
  input  logic [W-1:0]            i_wb,
  input  logic [NUM_PORTS*SW-1:0] i_rseg,
  output logic [NUM_PORTS*W-1:0]  o_rk,
  output logic [NUM_PORTS*W-1:0]  o_rb
);
  import exp_lut_pkg::*;

  logic [W-1:0] r_k [NUM_SEGMENTS];
  logic [W-1:0] r_b [NUM_SEGMENTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
        r_k[i] <= W'(default_k(i));
        r_b[i] <= W'(default_b(i));
      end
    end else if (i_we) begin
      r_k[i_wseg] <= i_wk;
      r_b[i_wseg] <= i_wb;
    end
  end

  always_comb begin
    o_rk = '0;
    o_rb = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_rk[p*W +: W] = r_k[i_rseg[p*SW +: SW]];
      o_rb[p*W +: W] = r_b[i_rseg[p*SW +: SW]];
    end
  end

endmodule

// File: rtl/exp_coeff_bank_ctrl.sv
// rtl/exp_coeff_bank_ctrl.sv - double-buffered exp() coefficient bank controller
//
// Purpose: two coefficient banks; lookups read the active bank through one
// register stage while config beats fill the shadow bank. A complete load
// swaps banks once the downstream datapath is idle; an incomplete load is
// discarded with a cfg_err pulse.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_valid/cfg_ready     config beat handshake
//   cfg_seg, cfg_k, cfg_b   segment index and coefficients of the beat
//   cfg_last                final beat of a table load
//   lut_busy                downstream lookups in flight, holds off the swap
//   lk_valid, lk_seg        lookup request, packed per-port segment indices
//   lk_valid_o              lookup result valid (one cycle after request)
//   k_coeff, b_intercept    packed per-port coefficient results
//   active_bank             bank serving lookups
//   swap_done               pulse in the cycle the swap takes effect
//   cfg_err                 pulse after an incomplete load is rejected
module exp_coeff_bank_ctrl #(
  parameter int Q            = exp_lut_pkg::Q,
  parameter int W            = exp_lut_pkg::W,
  parameter int NUM_SEGMENTS = exp_lut_pkg::NUM_SEGMENTS,
  parameter int NUM_PORTS    = 32,
  localparam int SW          = $clog2(NUM_SEGMENTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [SW-1:0]           cfg_seg,
  input  logic [W-1:0]            cfg_k,
  input  logic [W-1:0]            cfg_b,
  input  logic                    cfg_last,
  input  logic                    lut_busy,
  input  logic                    lk_valid,
  input  logic [NUM_PORTS*SW-1:0] lk_seg,
  output logic                    lk_valid_o,
  output logic [NUM_PORTS*W-1:0]  k_coeff,
  output logic [NUM_PORTS*W-1:0]  b_intercept,
  output logic                    active_bank,
  output logic                    swap_done,
  output logic                    cfg_err
);
  import exp_lut_pkg::*;

  if (Q < 1 || Q >= W) begin : g_bad_q
    $error("Q must lie in 1..W-1");
  end
  if ((1 << SW) != NUM_SEGMENTS) begin : g_bad_segments
    $error("NUM_SEGMENTS must be a power of two");
  end

  localparam logic [NUM_SEGMENTS-1:0] FULL_MASK = '1;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [NUM_SEGMENTS-1:0]  r_mask;
  logic [NUM_SEGMENTS-1:0]  w_mask_next;
  logic [NUM_SEGMENTS-1:0]  w_mask_incl;
  logic                     r_active;
  logic                     r_lk_valid_o;
  logic [NUM_PORTS*W-1:0]   r_k_out;
  logic [NUM_PORTS*W-1:0]   r_b_out;
  logic                     r_cfg_err;
  logic                     w_accepting;
  logic                     w_cfg_fire;
  logic                     w_err;
  logic                     w_swap;
  logic [NUM_PORTS*W-1:0]   w_k0;
  logic [NUM_PORTS*W-1:0]   w_b0;
  logic [NUM_PORTS*W-1:0]   w_k1;
  logic [NUM_PORTS*W-1:0]   w_b1;
  logic [NUM_PORTS*W-1:0]   w_rd_k;
  logic [NUM_PORTS*W-1:0]   w_rd_b;

  // rst_n gates ready so that no beat looks accepted while reset is held.
  assign w_cfg_fire = w_accepting & cfg_valid & rst_n;

  // Only the shadow bank (the one not being read) ever takes a write.
  exp_coeff_bank #(
    .W(W), .NUM_SEGMENTS(NUM_SEGMENTS), .NUM_PORTS(NUM_PORTS)
  ) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_cfg_fire & r_active),
    .i_wseg (cfg_seg),
    .i_wk   (cfg_k),
    .i_wb   (cfg_b),
    .i_rseg (lk_seg),
    .o_rk   (w_k0),
    .o_rb   (w_b0)
  );

  exp_coeff_bank #(
    .W(W), .NUM_SEGMENTS(NUM_SEGMENTS), .NUM_PORTS(NUM_PORTS)
  ) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_cfg_fire & ~r_active),
    .i_wseg (cfg_seg),
    .i_wk   (cfg_k),
    .i_wb   (cfg_b),
    .i_rseg (lk_seg),
    .o_rk   (w_k1),
    .o_rb   (w_b1)
  );

  assign w_rd_k = r_active ? w_k1 : w_k0;
  assign w_rd_b = r_active ? w_b1 : w_b0;

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_accepting  = 1'b0;
    w_err        = 1'b0;
    w_swap       = 1'b0;
    w_mask_incl  = r_mask | (NUM_SEGMENTS'(1) << cfg_seg);
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        w_accepting = 1'b1;
        if (cfg_valid) begin
          if (cfg_last) begin
            // The closing beat itself counts toward completeness.
            if (w_mask_incl == FULL_MASK) begin
              w_mask_next  = w_mask_incl;
              w_state_next = ST_WAIT_SWAP;
            end else begin
              w_err        = 1'b1;
              w_mask_next  = '0;
              w_state_next = ST_IDLE;
            end
          end else begin
            w_mask_next  = w_mask_incl;
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (!lut_busy) w_state_next = ST_SWAP;
      end
      ST_SWAP: begin
        // r_active still points at the old bank during this cycle, so a
        // lookup issued now sees the old table.
        w_swap       = 1'b1;
        w_mask_next  = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_mask_next  = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_active     <= 1'b0;
      r_lk_valid_o <= 1'b0;
      r_k_out      <= '0;
      r_b_out      <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_mask       <= w_mask_next;
      r_lk_valid_o <= lk_valid;
      r_cfg_err    <= w_err;
      if (w_swap) r_active <= ~r_active;
      if (lk_valid) begin
        r_k_out <= w_rd_k;
        r_b_out <= w_rd_b;
      end
    end
  end

  assign cfg_ready   = w_accepting & rst_n;
  assign lk_valid_o  = r_lk_valid_o;
  assign k_coeff     = r_k_out;
  assign b_intercept = r_b_out;
  assign active_bank = r_active;
  assign swap_done   = w_swap;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_exp_coeff_bank_ctrl.sv
// tb/tb_exp_coeff_bank_ctrl.sv - self-checking bench for exp_coeff_bank_ctrl
module tb_exp_coeff_bank_ctrl;
  localparam int W  = 32;
  localparam int NP = 32;
  localparam int SW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_last = 1'b0;
  logic                 lut_busy = 1'b0;
  logic                 lk_valid = 1'b0;
  logic [SW-1:0]        cfg_seg = '0;
  logic [W-1:0]         cfg_k = '0;
  logic [W-1:0]         cfg_b = '0;
  logic [NP*SW-1:0]     lk_seg = '0;
  logic                 cfg_ready;
  logic                 lk_valid_o;
  logic                 active_bank;
  logic                 swap_done;
  logic                 cfg_err;
  logic [NP*W-1:0]      k_coeff;
  logic [NP*W-1:0]      b_intercept;

  exp_coeff_bank_ctrl #(.Q(26), .W(W), .NUM_SEGMENTS(8), .NUM_PORTS(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_seg     (cfg_seg),
    .cfg_k       (cfg_k),
    .cfg_b       (cfg_b),
    .cfg_last    (cfg_last),
    .lut_busy    (lut_busy),
    .lk_valid    (lk_valid),
    .lk_seg      (lk_seg),
    .lk_valid_o  (lk_valid_o),
    .k_coeff     (k_coeff),
    .b_intercept (b_intercept),
    .active_bank (active_bank),
    .swap_done   (swap_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] dk [8];
  logic [31:0] db [8];

  // Reference model: two tables, which one is live, and where the load stands.
  logic [31:0]     mk [2][8];
  logic [31:0]     mb [2][8];
  bit              m_active;
  bit              m_wait;
  bit              m_swap;
  logic [7:0]      m_mask;
  logic [NP*W-1:0] ek;
  logic [NP*W-1:0] eb;
  bit              evo;
  bit              eerr;

  typedef struct {
    bit          vld;
    logic [2:0]  seg;
    logic [31:0] k;
    logic [31:0] b;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [NP*W-1:0] rep(input logic [31:0] v);
    return {NP{v}};
  endfunction

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic check_vec(input string nm, input logic [NP*W-1:0] act, input logic [NP*W-1:0] exp);
    int bad;
    bad = -1;
    for (int p = NP - 1; p >= 0; p--)
      if (act[p*W +: W] !== exp[p*W +: W]) bad = p;
    n_total++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s port %0d: got %h expected %h at %0t", nm, bad,
                  act[bad*W +: W], exp[bad*W +: W], $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mk[0][s] = dk[s]; mk[1][s] = dk[s];
      mb[0][s] = db[s]; mb[1][s] = db[s];
    end
    m_active = 1'b0; m_wait = 1'b0; m_swap = 1'b0; m_mask = '0;
    ek = '0; eb = '0; evo = 1'b0; eerr = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs; checks every output.
  task automatic cyc();
    bit rdy;
    rdy = !m_wait && !m_swap;
    check_bit("cfg_ready", cfg_ready, rdy);
    check_bit("swap_done", swap_done, m_swap);
    check_bit("active_bank", active_bank, m_active);
    if (lk_valid) begin
      for (int p = 0; p < NP; p++) begin
        ek[p*W +: W] = mk[m_active][lk_seg[p*SW +: SW]];
        eb[p*W +: W] = mb[m_active][lk_seg[p*SW +: SW]];
      end
    end
    evo  = lk_valid;
    eerr = 1'b0;
    if (rdy && cfg_valid) begin
      mk[~m_active][cfg_seg] = cfg_k;
      mb[~m_active][cfg_seg] = cfg_b;
      m_mask[cfg_seg] = 1'b1;
      if (cfg_last) begin
        if (m_mask == 8'hFF) m_wait = 1'b1;
        else begin eerr = 1'b1; m_mask = '0; end
      end
    end else if (m_wait) begin
      if (!lut_busy) begin m_wait = 1'b0; m_swap = 1'b1; end
    end else if (m_swap) begin
      m_active = ~m_active; m_swap = 1'b0; m_mask = '0;
    end
    @(posedge clk);
    #1;
    check_bit("lk_valid_o", lk_valid_o, evo);
    check_bit("cfg_err", cfg_err, eerr);
    check_vec("k_coeff", k_coeff, ek);
    check_vec("b_intercept", b_intercept, eb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_last = 1'b0; lut_busy = 1'b0; lk_valid = 1'b0;
    model_reset();
    #3;
    check_bit("rst_active_bank", active_bank, 1'b0);
    check_bit("rst_lk_valid_o", lk_valid_o, 1'b0);
    check_bit("rst_cfg_ready", cfg_ready, 1'b0);
    check_bit("rst_swap_done", swap_done, 1'b0);
    check_bit("rst_cfg_err", cfg_err, 1'b0);
    check_vec("rst_k", k_coeff, '0);
    check_vec("rst_b", b_intercept, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_bit("post_rst_cfg_ready", cfg_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_beats(input int first, input int last_seg, input int base, input bit with_last);
    for (int s = first; s <= last_seg; s++) begin
      cfg_valid = 1'b1;
      cfg_seg   = s[2:0];
      cfg_k     = base + s;
      cfg_b     = base + s;
      cfg_last  = with_last && (s == last_seg);
      cyc();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic lookup_all(input logic [2:0] seg);
    lk_valid = 1'b1;
    lk_seg   = {NP{seg}};
    cyc();
    lk_valid = 1'b0;
  endtask

  task automatic wait_swap();
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      seen = swap_done;
      cyc();
      n++;
    end
    check_bit("swap_seen", seen, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nseg;
    dk = '{32'h02E57078, 32'h03288B9B, 32'h0371B996, 32'h03C18722,
           32'h04188DB7, 32'h047774AE, 32'h04DEF287, 32'h054FCE46};
    db = '{32'h04000000, 32'h03F79C9B, 32'h03E5511D, 32'h03C76408,
           32'h039BE0BD, 32'h03609063, 32'h0312F200, 32'h02B031B9};
    for (int s = 0; s < 8; s++) tbl.push_back('{1'b1, 3'(s), dk[s], db[s]});
    tbl.push_back('{1'b0, 3'd2, dk[7], db[7]});

    do_reset();

    // Default table through every port, then a held result with lk_valid=0.
    foreach (tbl[i]) begin
      lk_valid = tbl[i].vld;
      lk_seg   = {NP{tbl[i].seg}};
      cyc();
      check_bit("tbl_valid", lk_valid_o, tbl[i].vld);
      check_vec("tbl_k", k_coeff, rep(tbl[i].k));
      check_vec("tbl_b", b_intercept, rep(tbl[i].b));
    end
    lk_valid = 1'b0;

    // Full load, idle downstream: swap to bank 1 and read the new table.
    load_beats(0, 7, 1, 1'b1);
    wait_swap();
    check_bit("swap_active1", active_bank, 1'b1);
    lookup_all(3'd5);
    check_vec("new_k_seg5", k_coeff, rep(32'h00000006));
    check_vec("new_b_seg5", b_intercept, rep(32'h00000006));

    // Full load while downstream is busy; lookup straddling the swap.
    do_reset();
    lut_busy = 1'b1;
    load_beats(0, 7, 1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check_bit("busy_cfg_ready", cfg_ready, 1'b0);
      lookup_all(3'd3);
      check_vec("busy_k", k_coeff, rep(32'h03C18722));
    end
    lut_busy = 1'b0;
    check_bit("busy_fall_no_swap", swap_done, 1'b0);
    cyc();
    check_bit("swap_one_after", swap_done, 1'b1);
    lookup_all(3'd3);
    check_vec("swap_cycle_old_k", k_coeff, rep(32'h03C18722));
    check_bit("after_swap_active", active_bank, 1'b1);
    lookup_all(3'd3);
    check_vec("after_swap_new_k", k_coeff, rep(32'h00000004));

    // Incomplete load: error pulse, no swap, defaults still served.
    do_reset();
    load_beats(0, 6, 1, 1'b1);
    check_bit("short_cfg_err", cfg_err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_bit("short_no_swap", swap_done, 1'b0);
      lookup_all(3'(i % 8));
      check_vec("short_default_k", k_coeff, rep(dk[i % 8]));
    end
    check_bit("short_active0", active_bank, 1'b0);

    // Reset mid-load: load abandoned and mask cleared.
    do_reset();
    load_beats(0, 3, 1, 1'b0);
    do_reset();
    check_bit("midrst_active0", active_bank, 1'b0);
    lookup_all(3'd6);
    check_vec("midrst_default_k", k_coeff, rep(dk[6]));
    check_vec("midrst_default_b", b_intercept, rep(db[6]));
    load_beats(4, 7, 5, 1'b1);
    check_bit("midrst_mask_empty", cfg_err, 1'b1);
    load_beats(0, 7, 9, 1'b1);
    wait_swap();
    lookup_all(3'd0);
    check_vec("midrst_full_k", k_coeff, rep(32'h00000009));

    // Randomized traffic against the model.
    nseg = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cfg_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) cfg_seg = 3'($urandom_range(0, 7));
      else cfg_seg = 3'(nseg);
      if (cfg_valid) nseg = (nseg + 1) % 8;
      cfg_last = ((cfg_seg == 3'd7) && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 30) == 0);
      cfg_k    = $urandom;
      cfg_b    = $urandom;
      lut_busy = ($urandom_range(0, 2) == 0);
      lk_valid = ($urandom_range(0, 1) == 1);
      for (int p = 0; p < NP; p++) lk_seg[p*SW +: SW] = 3'($urandom_range(0, 7));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
